// File: rtl/spart_pkg.sv
// spart_pkg: constants and types shared by the SPART receiver, transmitter
// and the receive FIFO.
//   BYTE_W        - width of one serial data byte
//   RX_FIFO_DEPTH - default number of entries in the receive FIFO
//   byte_t        - one data byte
package spart_pkg;

    localparam int BYTE_W        = 8;
    localparam int RX_FIFO_DEPTH = 8;

    typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/rx_fifo_mem.sv
// rx_fifo_mem: DEPTH x BYTE_W storage for rx_fifo. It has one synchronous
// write port and one asynchronous read port. The contents are not reset.
// Ports:
//   clk   - system clock (writes on rising edge)
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational from raddr)
module rx_fifo_mem
    import spart_pkg::*;
#(
    parameter int DEPTH = RX_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  byte_t         wdata,
    input  logic [AW-1:0] raddr,
    output byte_t         rdata
);

    byte_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rx_fifo.sv
// rx_fifo: byte FIFO that sits between the SPART receiver and the processor.
// A rising edge on rda captures rx_data. The capture is acknowledged with a
// one-cycle clr_rda pulse. The processor pops the head entry with rd_en, and
// the head entry is always shown on rd_data (show-ahead).
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset
//   rda     - receiver byte-ready level
//   rx_data - receiver byte
//   clr_rda - registered one-cycle acknowledge to the receiver
//   rd_en   - pop strobe; it is ignored while empty
//   rd_data - head entry; don't-care while empty
//   empty   - high when count is 0
//   full    - high when count is DEPTH
//   count   - number of stored entries
//   overrun - sticky flag set when a byte is dropped (RX_FIFO_OVERRUN_EN only)
//   ovr_clr - clears overrun (RX_FIFO_OVERRUN_EN only)
// Optional feature macro: RX_FIFO_OVERRUN_EN
module rx_fifo
    import spart_pkg::*;
#(
    parameter int DEPTH = RX_FIFO_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rda,
    input  logic [7:0]       rx_data,
    output logic             clr_rda,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic             empty,
    output logic             full,
`ifdef RX_FIFO_OVERRUN_EN
    output logic             overrun,
    input  logic             ovr_clr,
`endif
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic          rda_q;
    logic          capture;
    logic          pop;
    logic          push;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // rda_q is cleared during reset. If rda is already high when reset is
    // released, the first cycle is therefore seen as a rising edge.
    assign capture = rda & ~rda_q;

    // empty and full depend only on the count register. This keeps rd_en off
    // every status path.
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    assign pop  = rd_en & ~empty;
    // When the FIFO is full, a pop in the same cycle frees a slot.
    assign push = capture & (~full | pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            rda_q   <= 1'b0;
            clr_rda <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            rda_q   <= rda;
            // The byte is acknowledged even when it is dropped. Otherwise the
            // receiver would hold rda high forever.
            clr_rda <= capture;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

`ifdef RX_FIFO_OVERRUN_EN
    // A drop has priority over ovr_clr, so an overrun seen in the same cycle
    // as a clear is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (capture && !push) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end
`endif

    rx_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (rx_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_rx_fifo.sv
// tb_rx_fifo: bench for rx_fifo. Stimulus tasks push every accepted byte into
// a queue of expected values. A monitor process compares rd_data with the
// head of that queue on every valid pop, and also counts clr_rda pulses.
// Optional feature macro: RX_FIFO_OVERRUN_EN
module tb_rx_fifo;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             rda;
    logic [7:0]       rx_data;
    logic             clr_rda;
    logic             rd_en;
    logic [7:0]       rd_data;
    logic             empty;
    logic             full;
    logic [CNT_W-1:0] count;
    logic             ovr_clr;
`ifdef RX_FIFO_OVERRUN_EN
    logic             overrun;
`endif

    int tests = 0;
    int fails = 0;
    int clr_seen = 0;
    int clr_exp = 0;
    int mcount = 0;
    bit mov = 1'b0;
    logic [7:0] exp_q[$];

    rx_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rda     (rda),
        .rx_data (rx_data),
        .clr_rda (clr_rda),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
`ifdef RX_FIFO_OVERRUN_EN
        .overrun (overrun),
        .ovr_clr (ovr_clr),
`endif
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: checks the popped data and the clr_rda pulse width on the
    // negative edge, away from the capturing edge.
    initial begin
        logic [7:0] e;
        bit clr_prev;
        clr_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                clr_prev = 1'b0;
            end else begin
                if (clr_prev) begin
                    tests++;
                    if (clr_rda) begin
                        fails++;
                        $display("FAIL clr_rda_width: got 1 expected 0");
                    end
                end
                if (clr_rda) clr_seen++;
                clr_prev = clr_rda;
                if (rd_en && !empty) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL pop_unexpected: got %0h expected none", rd_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (rd_data !== e) begin
                            fails++;
                            $display("FAIL pop_data: got %0h expected %0h", rd_data, e);
                        end
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_clr();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            rd_en = 1'b0;
            ovr_clr = 1'b0;
            n++;
        end while (!clr_rda && n < 8);
        check("clr_rda_seen", {31'b0, clr_rda}, 32'd1);
        rda = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit with_pop, input bit with_oclr);
        bit popv, acc;
        @(posedge clk); #1;
        popv = with_pop && (mcount > 0);
        acc = (mcount < DEPTH) || popv;
        if (acc) exp_q.push_back(b);
        if (acc && !popv) mcount++;
        if (popv && !acc) mcount--;
        if (!acc) mov = 1'b1;
        else if (with_oclr) mov = 1'b0;
        rda = 1'b1;
        rx_data = b;
        rd_en = with_pop;
        ovr_clr = with_oclr;
        clr_exp++;
        wait_clr();
    endtask

    task automatic pop_one();
        @(posedge clk); #1;
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        if (mcount > 0) mcount--;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        mcount = 0;
        mov = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, {28'b0, count}, mcount);
        check({tag, "_empty"}, {31'b0, empty}, {31'b0, (mcount == 0)});
        check({tag, "_full"}, {31'b0, full}, {31'b0, (mcount == DEPTH)});
    endtask

    task automatic check_clr(input string tag);
        idle(1);
        check({tag, "_clr_pulses"}, clr_seen, clr_exp);
    endtask

`ifdef RX_FIFO_OVERRUN_EN
    task automatic clear_ovr();
        @(posedge clk); #1;
        ovr_clr = 1'b1;
        @(posedge clk); #1;
        ovr_clr = 1'b0;
        mov = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        rda = 1'b0;
        rx_data = 8'h00;
        rd_en = 1'b0;
        ovr_clr = 1'b0;
        idle(3);
        rst = 1'b0;

        // Reset state, and popping while empty.
        check("rst_empty", {31'b0, empty}, 32'd1);
        check("rst_full", {31'b0, full}, 32'd0);
        check("rst_count", {28'b0, count}, 32'd0);
        check("rst_clr_rda", {31'b0, clr_rda}, 32'd0);
        pop_one();
        pop_one();
        check_state("empty_pop");

        // Single byte.
        push_byte(8'hA5, 1'b0, 1'b0);
        check("single_count", {28'b0, count}, 32'd1);
        check("single_rd_data", {24'b0, rd_data}, 32'hA5);
        check_clr("single");
        pop_one();
        check_state("single_pop");

        // Fill, then wrap the pointers.
        for (int i = 1; i <= 8; i++) push_byte(8'(i), 1'b0, 1'b0);
        check_state("fill");
        for (int i = 0; i < 3; i++) pop_one();
        for (int i = 9; i <= 11; i++) push_byte(8'(i), 1'b0, 1'b0);
        check_state("wrap");

        // Drop a byte when full. Overrun handling is checked here too.
        push_byte(8'hFF, 1'b0, 1'b0);
        check_state("drop");
        check_clr("drop");
`ifdef RX_FIFO_OVERRUN_EN
        check("ovr_set", {31'b0, overrun}, {31'b0, mov});
        clear_ovr();
        check("ovr_clr", {31'b0, overrun}, 32'd0);
        push_byte(8'hFF, 1'b0, 1'b1);
        check("ovr_drop_and_clr", {31'b0, overrun}, {31'b0, mov});
        clear_ovr();
        check("ovr_clr2", {31'b0, overrun}, 32'd0);
`endif

        // Push and pop in the same cycle while full.
        push_byte(8'h55, 1'b1, 1'b0);
        check_state("full_pushpop");
        for (int i = 0; i < 8; i++) pop_one();
        check_state("drain");

        // Push and pop in the same cycle while count is 1.
        push_byte(8'h11, 1'b0, 1'b0);
        push_byte(8'h22, 1'b1, 1'b0);
        check_state("one_pushpop");
        pop_one();
        check_state("one_drain");
        check_clr("one");

        // Reset in the middle of operation.
        for (int i = 0; i < 5; i++) push_byte(8'hA0 + 8'(i), 1'b0, 1'b0);
        check_state("mid5");
        pulse_reset();
        check_state("mid_rst");
        push_byte(8'h3C, 1'b0, 1'b0);
        check("mid_rd_data", {24'b0, rd_data}, 32'h3C);
        pop_one();
        check_state("mid_drain");

        // rda already high when reset is released.
        @(posedge clk); #1;
        rst = 1'b1;
        rda = 1'b1;
        rx_data = 8'h77;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        mov = 1'b0;
        exp_q.push_back(8'h77);
        mcount = 1;
        clr_exp++;
        wait_clr();
        check_state("rst_rda");
        check("rst_rda_data", {24'b0, rd_data}, 32'h77);
        pop_one();
        check_state("rst_rda_drain");
        check_clr("final");
        check("queue_drained", exp_q.size(), 32'd0);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
